bullet_scheduler: RTL

- Owns a shared pool of projectile slots for the two-player VGA game.
- Arbitrates player 1 and player 2 shoot requests into free slots.
- Advances every active bullet once per video frame and retires bullets that leave the screen.
- Answers per-pixel queries from the renderer so bullets can be drawn alongside the rest of the scene.

---
 rtl/game_pkg.sv | 32 +++
 rtl/shoot_request.sv | 57 +++++
 rtl/bullet_scheduler.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types and screen constants for the two-player game: bullet slot
// layout, owner encoding, scheduler states and a pixel-span helper.
package game_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    typedef enum logic {
        OWNER_P1 = 1'b0,
        OWNER_P2 = 1'b1
    } owner_e;

    typedef struct packed {
        logic       active;
        owner_e     owner;
        logic [9:0] x;
        logic [9:0] y;
    } bullet_slot_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MOVE,
        ST_SPAWN,
        ST_COOL
    } sched_state_e;

    // True when p lies in [lo, lo+len-1]; 11-bit math so lo near 1023 cannot wrap.
    function automatic logic in_span(input logic [9:0] lo, input int len, input logic [9:0] p);
        return ({1'b0, p} >= {1'b0, lo}) && ({1'b0, p} <= ({1'b0, lo} + 11'(len - 1)));
    endfunction

endpackage

// File: rtl/shoot_request.sv
// Per-player shoot request: edge detector, pending flag and cooldown counter.
// With BULLET_AUTOFIRE_EN defined, a held shoot input re-arms pending once cooldown is 0.
module shoot_request #(
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic shoot_i,
    input  logic grant_i,
    input  logic frame_dec_i,
    output logic pending_o,
    output logic ready_o
);

    localparam int CW = $clog2(COOLDOWN_FRAMES + 1);

    logic          shoot_prev_q, shoot_prev_d;
    logic          pending_q, pending_d;
    logic [CW-1:0] cool_q, cool_d;

    always_comb begin
        shoot_prev_d = shoot_i;
        pending_d    = pending_q;
        cool_d       = cool_q;
        if (grant_i) begin
            cool_d = CW'(COOLDOWN_FRAMES);
        end else if (frame_dec_i && (cool_q != '0)) begin
            cool_d = cool_q - CW'(1);
        end
        // A grant wins over a coincident edge; an edge while pending is absorbed.
        if (grant_i) begin
            pending_d = 1'b0;
        end else if (shoot_i && !shoot_prev_q) begin
            pending_d = 1'b1;
`ifdef BULLET_AUTOFIRE_EN
        end else if (shoot_i && (cool_q == '0)) begin
            pending_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            shoot_prev_q <= 1'b0;
            pending_q    <= 1'b0;
            cool_q       <= '0;
        end else begin
            shoot_prev_q <= shoot_prev_d;
            pending_q    <= pending_d;
            cool_q       <= cool_d;
        end
    end

    assign pending_o = pending_q;
    assign ready_o   = (cool_q == '0);

endmodule

// File: rtl/bullet_scheduler.sv
// Shared bullet slot pool: per-frame move/spawn/cooldown sequencer plus a
// one-cycle pixel hit query. BULLET_AUTOFIRE_EN enables held-button autofire.
module bullet_scheduler
    import game_pkg::*;
#(
    parameter int NUM_SLOTS       = 4,
    parameter int MAX_PER_PLAYER  = 2,
    parameter int SPEED           = 4,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int BULLET_W        = 4,
    parameter int BULLET_H        = 2
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       frame_tick_i,
    input  logic       player_1_shoot_i,
    input  logic       player_2_shoot_i,
    input  logic [9:0] player_1_x_i,
    input  logic [9:0] player_1_y_i,
    input  logic [9:0] player_2_x_i,
    input  logic [9:0] player_2_y_i,
    input  logic [9:0] query_hpos_i,
    input  logic [9:0] query_vpos_i,
    output logic       bullet_pixel_o,
    output logic       bullet_owner_o,
    output logic [1:0] player_1_count_o,
    output logic [1:0] player_2_count_o,
    output logic       busy_o
);

    localparam int IW   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CNTW = $clog2(NUM_SLOTS + 1);
    localparam logic [CNTW-1:0] MAX_C = CNTW'(MAX_PER_PLAYER);

    sched_state_e                 state_q, state_d;
    logic [IW-1:0]                idx_q, idx_d;
    logic                         rr_q, rr_d;
    bullet_slot_t [NUM_SLOTS-1:0] slots_q, slots_d;
    logic [1:0]                   cnt1_q, cnt1_d, cnt2_q, cnt2_d;
    logic                         pixel_q, pixel_d, owner_q, owner_d;

    logic [1:0]      pend, ready, grant, elig;
    logic            frame_dec;
    logic            free_any;
    logic [IW-1:0]   free_idx;
    logic [CNTW-1:0] c1, c2;
    bullet_slot_t    cur_slot;
    logic [11:0]     move_x;
    logic            move_out;
    logic [NUM_SLOTS-1:0] hit;

    shoot_request #(.COOLDOWN_FRAMES(COOLDOWN_FRAMES)) u_req [1:0] (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .shoot_i     ({player_2_shoot_i, player_1_shoot_i}),
        .grant_i     (grant),
        .frame_dec_i (frame_dec),
        .pending_o   (pend),
        .ready_o     (ready)
    );

    // Lowest free slot and live per-owner occupancy of the current slot registers.
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        c1       = '0;
        c2       = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slots_q[i].active) begin
                free_any = 1'b1;
                free_idx = IW'(i);
            end
        end
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slots_q[i].active) begin
                if (slots_q[i].owner == OWNER_P2) c2 = c2 + CNTW'(1);
                else                              c1 = c1 + CNTW'(1);
            end
        end
    end

    assign elig[0] = pend[0] && ready[0] && (c1 < MAX_C) && free_any;
    assign elig[1] = pend[1] && ready[1] && (c2 < MAX_C) && free_any;

    // Two's complement step; bit 11 set means the bullet went left of column 0.
    assign cur_slot = slots_q[idx_q];
    assign move_x   = (cur_slot.owner == OWNER_P2) ? ({2'b00, cur_slot.x} - 12'(SPEED))
                                                   : ({2'b00, cur_slot.x} + 12'(SPEED));
    assign move_out = move_x[11] || (move_x > 12'(H_ACTIVE - 1));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rr_d      = rr_q;
        slots_d   = slots_q;
        grant     = 2'b00;
        frame_dec = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_tick_i) begin
                    state_d = ST_MOVE;
                    idx_d   = '0;
                end
            end
            ST_MOVE: begin
                if (cur_slot.active) begin
                    if (move_out) slots_d[idx_q]   = '0;
                    else          slots_d[idx_q].x = move_x[9:0];
                end
                if (idx_q == IW'(NUM_SLOTS - 1)) begin
                    state_d = ST_SPAWN;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            ST_SPAWN: begin
                // rr_q = 0 favours player 1 when both are eligible.
                if (elig[0] && (!elig[1] || !rr_q)) grant = 2'b01;
                else if (elig[1])                   grant = 2'b10;
                if (grant != 2'b00) begin
                    slots_d[free_idx].active = 1'b1;
                    slots_d[free_idx].owner  = grant[1] ? OWNER_P2 : OWNER_P1;
                    slots_d[free_idx].x      = grant[1] ? player_2_x_i : player_1_x_i;
                    slots_d[free_idx].y      = grant[1] ? player_2_y_i : player_1_y_i;
                    rr_d                     = grant[0];
                end
                if (idx_q == '0) begin
                    idx_d = IW'(1);
                end else begin
                    state_d = ST_COOL;
                    idx_d   = '0;
                end
            end
            ST_COOL: begin
                frame_dec = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_hit
        assign hit[g] = slots_q[g].active
                     && in_span(slots_q[g].x, BULLET_W, query_hpos_i)
                     && in_span(slots_q[g].y, BULLET_H, query_vpos_i);
    end

    always_comb begin
        pixel_d = |hit;
        owner_d = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (hit[i]) owner_d = (slots_q[i].owner == OWNER_P2);
        end
        cnt1_d = 2'(c1);
        cnt2_d = 2'(c2);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            rr_q    <= 1'b0;
            slots_q <= '0;
            cnt1_q  <= '0;
            cnt2_q  <= '0;
            pixel_q <= 1'b0;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rr_q    <= rr_d;
            slots_q <= slots_d;
            cnt1_q  <= cnt1_d;
            cnt2_q  <= cnt2_d;
            pixel_q <= pixel_d;
            owner_q <= owner_d;
        end
    end

    assign bullet_pixel_o   = pixel_q;
    assign bullet_owner_o   = owner_q;
    assign player_1_count_o = cnt1_q;
    assign player_2_count_o = cnt2_q;
    assign busy_o           = (state_q != ST_IDLE);

endmodule
